// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multicycle sequencer: state encodings, control-word
// field positions and write-back select codes, also used by control ROM builders.
package multicycle_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_ERROR  = 3'd7
    } state_t;

    localparam int CW_PCSEL     = 19;
    localparam int CW_IMMSEL_HI = 18;
    localparam int CW_IMMSEL_LO = 16;
    localparam int CW_REGWEN    = 15;
    localparam int CW_BRUN      = 14;
    localparam int CW_BSEL      = 13;
    localparam int CW_ASEL      = 12;
    localparam int CW_ALUSEL_HI = 11;
    localparam int CW_ALUSEL_LO = 8;
    localparam int CW_MEMRW     = 7;
    localparam int CW_SSIZE_HI  = 6;
    localparam int CW_SSIZE_LO  = 5;
    localparam int CW_LTYPE_HI  = 4;
    localparam int CW_LTYPE_LO  = 2;
    localparam int CW_WBSEL_HI  = 1;
    localparam int CW_WBSEL_LO  = 0;

    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    // Stores always touch memory; loads are register writes that take data from memory.
    function automatic logic needs_mem(input logic mem_rw, input logic reg_wen,
                                       input logic [1:0] wb_sel);
        return mem_rw | (reg_wen & (wb_sel == WB_MEM));
    endfunction

endpackage

// File: rtl/multicycle_sequencer_mc_wait_timer.sv
// Memory wait counter: counts cycles a request is pending without ready and
// flags the cycle that would otherwise become the TIMEOUT-th unanswered wait.
module mc_wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic req,
    input  logic ready,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (req && !ready) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    // Ready in the terminal cycle still completes the handshake.
    assign expired = req & ~ready & (count_q == LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control with
// memory handshakes, a wait timeout into a sticky ERROR state and a retire counter.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CW_W    = 20
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic [CW_W-1:0] ctrl_word,
    output logic            imem_req,
    input  logic            imem_ready,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ready,
    output logic            ir_we,
    output logic            pc_we,
    output logic            pc_sel,
    output logic            reg_we,
    output logic [2:0]      state,
    output logic            err,
    output logic [31:0]     instret
);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] instret_q;
    logic        mem_ready;
    logic        timed_out;
    logic        unused_cw;

    assign unused_cw = ^ctrl_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (state_q == ST_WB) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign mem_ready = (state_q == ST_MEM) ? dmem_ready : imem_ready;

    mc_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_d != state_q),
        .req     (imem_req | dmem_req),
        .ready   (mem_ready),
        .expired (timed_out)
    );

    // Fetch request is gated by rst_n so nothing is requested while reset is held.
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 1'b0;
        reg_we   = 1'b0;
        err      = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req = run & rst_n;
                ir_we    = run & rst_n & imem_ready;
                if (ir_we) begin
                    state_d = ST_DECODE;
                end else if (timed_out) begin
                    state_d = ST_ERROR;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                state_d = needs_mem(ctrl_word[CW_MEMRW], ctrl_word[CW_REGWEN],
                                    ctrl_word[CW_WBSEL_HI:CW_WBSEL_LO]) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = ctrl_word[CW_MEMRW];
                if (dmem_ready) begin
                    state_d = ST_WB;
                end else if (timed_out) begin
                    state_d = ST_ERROR;
                end
            end
            ST_WB: begin
                pc_we   = 1'b1;
                pc_sel  = ctrl_word[CW_PCSEL];
                reg_we  = ctrl_word[CW_REGWEN];
                state_d = ST_FETCH;
            end
            ST_ERROR: err = 1'b1;
            default:  state_d = ST_ERROR;
        endcase
    end

    assign state   = state_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed testbench for multicycle_sequencer: vector table for the main
// instruction flows plus hand sequences for timeout, mid-MEM reset and wrap.
module tb_multicycle_sequencer;

    localparam int TO = 4;
    localparam logic [19:0] ADD = 20'h08001;
    localparam logic [19:0] LD  = 20'h08008;
    localparam logic [19:0] ST  = 20'h000C0;
    localparam logic [19:0] BR  = 20'h84000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [19:0] ctrl_word;
    logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready;
    logic        ir_we, pc_we, pc_sel, reg_we, err;
    logic [2:0]  state;
    logic [31:0] instret;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        run;
        logic [19:0] cw;
        logic        ir;
        logic        dr;
        logic [2:0]  st;
        logic        imr, irwe, dmr, dwe, pcwe, pcsel, rwe;
        logic [31:0] inst;
    } vec_t;

    vec_t tv[$];

    multicycle_sequencer #(.TIMEOUT(TO), .CW_W(20)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .ctrl_word  (ctrl_word),
        .imem_req   (imem_req),
        .imem_ready (imem_ready),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ready (dmem_ready),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .reg_we     (reg_we),
        .state      (state),
        .err        (err),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [19:0] cw, input logic ir,
                                input logic dr, input logic [2:0] st, input logic imr,
                                input logic irwe, input logic dmr, input logic dwe,
                                input logic pcwe, input logic pcsel, input logic rwe,
                                input logic [31:0] inst);
        vec_t t;
        t.run = r;   t.cw = cw;     t.ir = ir;       t.dr = dr;   t.st = st;
        t.imr = imr; t.irwe = irwe; t.dmr = dmr;     t.dwe = dwe;
        t.pcwe = pcwe; t.pcsel = pcsel; t.rwe = rwe; t.inst = inst;
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives inputs just after the falling edge and leaves time for outputs to settle.
    task automatic applyStimulus(input logic r, input logic [19:0] cw, input logic ir, input logic dr);
        @(negedge clk);
        run = r; ctrl_word = cw; imem_ready = ir; dmem_ready = dr;
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 5; i++) tv.push_back(mk(0, ADD, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, ADD, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, ADD, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, ADD, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, ADD, 1, 1, 4, 0, 0, 0, 0, 1, 0, 1, 0));
        tv.push_back(mk(1, LD,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        tv.push_back(mk(1, LD,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        tv.push_back(mk(0, LD,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tv.push_back(mk(0, LD,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tv.push_back(mk(1, LD,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        tv.push_back(mk(1, LD,  1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1));
        tv.push_back(mk(1, LD,  1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        tv.push_back(mk(1, LD,  1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1));
        for (int i = 0; i < 3; i++) tv.push_back(mk(1, LD, 1, 0, 3, 0, 0, 1, 0, 0, 0, 0, 1));
        tv.push_back(mk(1, LD,  1, 1, 3, 0, 0, 1, 0, 0, 0, 0, 1));
        tv.push_back(mk(1, LD,  1, 0, 4, 0, 0, 0, 0, 1, 0, 1, 1));
        tv.push_back(mk(1, ST,  1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 2));
        tv.push_back(mk(1, ST,  1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2));
        tv.push_back(mk(1, ST,  1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 2));
        tv.push_back(mk(1, ST,  1, 1, 3, 0, 0, 1, 1, 0, 0, 0, 2));
        tv.push_back(mk(1, ST,  1, 1, 4, 0, 0, 0, 0, 1, 0, 0, 2));
        tv.push_back(mk(1, BR,  1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 3));
        tv.push_back(mk(1, BR,  1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 3));
        tv.push_back(mk(1, BR,  1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 3));
        tv.push_back(mk(1, BR,  1, 1, 4, 0, 0, 0, 0, 1, 1, 0, 3));
        tv.push_back(mk(0, BR,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4));

        rst_n = 1'b0; run = 1'b1; ctrl_word = ADD; imem_ready = 1'b1; dmem_ready = 1'b1;
        @(negedge clk); #1;
        checkOutput("reset.state",    32'(state), 32'd0);
        checkOutput("reset.imem_req", 32'(imem_req), 32'd0);
        checkOutput("reset.ir_we",    32'(ir_we), 32'd0);
        checkOutput("reset.err",      32'(err), 32'd0);
        checkOutput("reset.instret",  instret, 32'd0);
        @(negedge clk);
        run = 1'b0;
        rst_n = 1'b1;

        foreach (tv[i]) begin
            applyStimulus(tv[i].run, tv[i].cw, tv[i].ir, tv[i].dr);
            checkOutput($sformatf("v%0d.state", i),    32'(state),    32'(tv[i].st));
            checkOutput($sformatf("v%0d.imem_req", i), 32'(imem_req), 32'(tv[i].imr));
            checkOutput($sformatf("v%0d.ir_we", i),    32'(ir_we),    32'(tv[i].irwe));
            checkOutput($sformatf("v%0d.dmem_req", i), 32'(dmem_req), 32'(tv[i].dmr));
            checkOutput($sformatf("v%0d.dmem_we", i),  32'(dmem_we),  32'(tv[i].dwe));
            checkOutput($sformatf("v%0d.pc_we", i),    32'(pc_we),    32'(tv[i].pcwe));
            checkOutput($sformatf("v%0d.pc_sel", i),   32'(pc_sel),   32'(tv[i].pcsel));
            checkOutput($sformatf("v%0d.reg_we", i),   32'(reg_we),   32'(tv[i].rwe));
            checkOutput($sformatf("v%0d.err", i),      32'(err),      32'd0);
            checkOutput($sformatf("v%0d.instret", i),  instret,       tv[i].inst);
        end

        // Reset while a load is stalled in MEM.
        applyStimulus(1, LD, 1, 0);
        applyStimulus(1, LD, 1, 0);
        applyStimulus(1, LD, 1, 0);
        applyStimulus(1, LD, 1, 0);
        checkOutput("midmem.state_before",    32'(state), 32'd3);
        checkOutput("midmem.dmem_req_before", 32'(dmem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midmem.dmem_req", 32'(dmem_req), 32'd0);
        checkOutput("midmem.state",    32'(state), 32'd0);
        checkOutput("midmem.instret",  instret, 32'd0);
        checkOutput("midmem.imem_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        imem_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        checkOutput("release.imem_req", 32'(imem_req), 32'd1);
        checkOutput("release.state",    32'(state), 32'd0);

        // Fetch timeout: the release cycle above is the first unanswered wait.
        for (int i = 2; i <= TO; i++) begin
            applyStimulus(1, ADD, 0, 0);
            checkOutput($sformatf("to.wait%0d.state", i),    32'(state), 32'd0);
            checkOutput($sformatf("to.wait%0d.imem_req", i), 32'(imem_req), 32'd1);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, ADD, 1, 1);
            checkOutput($sformatf("to.err%0d.state", i),    32'(state), 32'd7);
            checkOutput($sformatf("to.err%0d.err", i),      32'(err), 32'd1);
            checkOutput($sformatf("to.err%0d.imem_req", i), 32'(imem_req), 32'd0);
            checkOutput($sformatf("to.err%0d.ir_we", i),    32'(ir_we), 32'd0);
            checkOutput($sformatf("to.err%0d.pc_we", i),    32'(pc_we), 32'd0);
        end

        @(negedge clk);
        rst_n = 1'b0;
        run = 1'b0;
        #1;
        checkOutput("rst2.state", 32'(state), 32'd0);
        checkOutput("rst2.err",   32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Retire counter wrap from all-ones.
        #1;
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        #1;
        checkOutput("wrap.preset", instret, 32'hFFFF_FFFF);
        applyStimulus(1, ADD, 1, 0);
        checkOutput("wrap.fetch.ir_we", 32'(ir_we), 32'd1);
        applyStimulus(1, ADD, 1, 0);
        applyStimulus(1, ADD, 1, 0);
        applyStimulus(1, ADD, 1, 0);
        checkOutput("wrap.wb.state",   32'(state), 32'd4);
        checkOutput("wrap.wb.pc_we",   32'(pc_we), 32'd1);
        checkOutput("wrap.wb.instret", instret, 32'hFFFF_FFFF);
        applyStimulus(0, ADD, 0, 0);
        checkOutput("wrap.state",   32'(state), 32'd0);
        checkOutput("wrap.instret", instret, 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
